// File: rtl/mem_bank_bl_wl_programmer.sv
// Tile bl/wl programmer: setup -> one-hot wl pulse -> hold per accepted row.
// Optional `CFG_PARITY_CHECK_EN adds a row_parity input and rejects bad rows.
module mem_bank_bl_wl_programmer #(
  parameter int NUM_BL       = 3,
  parameter int NUM_WL       = 3,
  parameter int ADDR_W       = 2,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [NUM_BL-1:0] row_bl,
  input  logic [ADDR_W-1:0] row_addr,
`ifdef CFG_PARITY_CHECK_EN
  input  logic              row_parity,
`endif
  output logic [NUM_BL-1:0] bl,
  output logic [NUM_WL-1:0] wl,
  output logic              busy,
  output logic              row_done,
  output logic              err
);

  localparam int MAX_SP =
    (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_C =
    (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  localparam int CNT_W =
    ($clog2(MAX_C + 1) < 1) ? 1 : $clog2(MAX_C + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]  WL_LIM   = NUM_WL[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_BL-1:0]  bl_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [NUM_WL-1:0]  wl_hot;
  logic               xfer;
  logic               addr_bad;
  logic               par_bad;
  logic               reject;
  logic               load;
  logic               done_n;
  logic               err_set;

  assign xfer     = row_valid & row_ready;
  assign addr_bad = {1'b0, row_addr} >= WL_LIM;
`ifdef CFG_PARITY_CHECK_EN
  assign par_bad  = ^{row_addr, row_bl, row_parity};
`else
  assign par_bad  = 1'b0;
`endif
  assign reject   = addr_bad | par_bad;
  assign load     = xfer & ~reject;

  always_comb begin
    wl_hot = '0;
    for (int i = 0; i < NUM_WL; i++)
      wl_hot[i] = (addr_q == ADDR_W'(i));
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    done_n  = 1'b0;
    err_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer && reject) begin
          err_set = 1'b1;
          done_n  = 1'b1;
        end else if (xfer) begin
          state_n = SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = PULSE_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with state.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bl_q      <= '0;
      addr_q    <= '0;
      bl        <= '0;
      wl        <= '0;
      row_ready <= 1'b1;
      busy      <= 1'b0;
      row_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        bl_q   <= row_bl;
        addr_q <= row_addr;
      end
      if (state_n == IDLE)
        bl <= '0;
      else if (load)
        bl <= row_bl;
      else
        bl <= bl_q;
      wl        <= (state_n == PULSE) ? wl_hot : '0;
      // A rejected row still costs one not-ready cycle.
      row_ready <= (state_n == IDLE) & ~xfer;
      busy      <= (state_n != IDLE);
      row_done  <= done_n;
      err       <= err | err_set;
    end
  end

endmodule

// File: tb/tb_mem_bank_bl_wl_programmer.sv
// Directed bench for mem_bank_bl_wl_programmer; outputs sampled on negedge.
// Parity cases run only when CFG_PARITY_CHECK_EN is defined.
module tb_mem_bank_bl_wl_programmer;

  logic       clk;
  logic       prog_reset;
  logic       row_valid;
  logic       row_ready;
  logic [2:0] row_bl;
  logic [1:0] row_addr;
  logic       row_parity;
  logic [2:0] bl;
  logic [2:0] wl;
  logic       busy;
  logic       row_done;
  logic       err;

  int total;
  int bad;

  logic [2:0] wl_tab [1:10];
  logic       dn_tab [1:10];

  mem_bank_bl_wl_programmer dut (
    .prog_clk   (clk),
    .prog_reset (prog_reset),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_bl     (row_bl),
    .row_addr   (row_addr),
`ifdef CFG_PARITY_CHECK_EN
    .row_parity (row_parity),
`endif
    .bl         (bl),
    .wl         (wl),
    .busy       (busy),
    .row_done   (row_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [2:0] b,
                     input logic [1:0] a,
                     input logic       p);
    row_valid  = 1'b1;
    row_bl     = b;
    row_addr   = a;
    row_parity = p;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wl_tab = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b000,
               3'b000, 3'b100, 3'b100, 3'b000, 3'b000};
    dn_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prog_reset = 1'b1;
    row_valid  = 1'b0;
    row_bl     = '0;
    row_addr   = '0;
    row_parity = 1'b0;
    @(negedge clk);
    tick();
    tick();
    chk("rst_ready", 32'(row_ready), 32'h1);
    chk("rst_bl", 32'(bl), 32'h0);
    chk("rst_wl", 32'(wl), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_done", 32'(row_done), 32'h0);
    prog_reset = 1'b0;
    tick();

    // single row 101 -> wl[1]
    put(3'b101, 2'd1, 1'b1);
    tick();
    row_valid = 1'b0;
    chk("s1_bl", 32'(bl), 32'h5);
    chk("s1_wl", 32'(wl), 32'h0);
    chk("s1_ready", 32'(row_ready), 32'h0);
    chk("s1_busy", 32'(busy), 32'h1);
    tick();
    chk("s2_wl", 32'(wl), 32'h2);
    chk("s2_bl", 32'(bl), 32'h5);
    tick();
    chk("s3_wl", 32'(wl), 32'h2);
    tick();
    chk("s4_wl", 32'(wl), 32'h0);
    chk("s4_bl", 32'(bl), 32'h5);
    chk("s4_done", 32'(row_done), 32'h0);
    tick();
    chk("s5_bl", 32'(bl), 32'h0);
    chk("s5_done", 32'(row_done), 32'h1);
    chk("s5_ready", 32'(row_ready), 32'h1);
    chk("s5_busy", 32'(busy), 32'h0);
    tick();
    chk("s6_done", 32'(row_done), 32'h0);

    // back-to-back with valid held
    put(3'b110, 2'd0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) put(3'b011, 2'd2, 1'b1);
      if (k == 6) row_valid = 1'b0;
      chk($sformatf("b2b_wl_c%0d", k), 32'(wl), 32'(wl_tab[k]));
      chk($sformatf("b2b_done_c%0d", k), 32'(row_done),
          32'(dn_tab[k]));
      if (k == 3) chk("b2b_bl_a", 32'(bl), 32'h6);
      if (k == 7) chk("b2b_bl_b", 32'(bl), 32'h3);
    end

    // bad address
    put(3'b000, 2'd3, 1'b0);
    tick();
    row_valid = 1'b0;
    chk("ba1_err", 32'(err), 32'h1);
    chk("ba1_done", 32'(row_done), 32'h1);
    chk("ba1_wl", 32'(wl), 32'h0);
    chk("ba1_ready", 32'(row_ready), 32'h0);
    tick();
    chk("ba2_wl", 32'(wl), 32'h0);
    chk("ba2_done", 32'(row_done), 32'h0);
    chk("ba2_ready", 32'(row_ready), 32'h1);
    put(3'b101, 2'd1, 1'b1);
    tick();
    row_valid = 1'b0;
    tick();
    chk("ba_good_wl", 32'(wl), 32'h2);
    chk("ba_good_err", 32'(err), 32'h1);
    tick();
    tick();
    tick();
    chk("ba_good_done", 32'(row_done), 32'h1);
    chk("ba_good_err2", 32'(err), 32'h1);
    tick();

    // reset mid-pulse
    put(3'b101, 2'd1, 1'b1);
    tick();
    row_valid = 1'b0;
    tick();
    chk("mr_wl_pre", 32'(wl), 32'h2);
    prog_reset = 1'b1;
    tick();
    chk("mr_bl", 32'(bl), 32'h0);
    chk("mr_wl", 32'(wl), 32'h0);
    chk("mr_ready", 32'(row_ready), 32'h1);
    chk("mr_done", 32'(row_done), 32'h0);
    chk("mr_err", 32'(err), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    put(3'b111, 2'd0, 1'b1);
    tick();
    chk("rv_busy", 32'(busy), 32'h0);
    chk("rv_bl", 32'(bl), 32'h0);
    chk("rv_ready", 32'(row_ready), 32'h1);
    row_valid  = 1'b0;
    prog_reset = 1'b0;
    tick();
    chk("rv_busy2", 32'(busy), 32'h0);

`ifdef CFG_PARITY_CHECK_EN
    put(3'b101, 2'd1, 1'b0);
    tick();
    row_valid = 1'b0;
    chk("par_err", 32'(err), 32'h1);
    chk("par_done", 32'(row_done), 32'h1);
    tick();
    chk("par_wl", 32'(wl), 32'h0);
    put(3'b101, 2'd1, 1'b1);
    tick();
    row_valid = 1'b0;
    chk("par_ok_bl", 32'(bl), 32'h5);
    tick();
    chk("par_ok_wl", 32'(wl), 32'h2);
    tick();
    tick();
    tick();
    chk("par_ok_done", 32'(row_done), 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
